// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port SRAM between NREQ requesters
// (index 0 = IFU fetch, index 1 = LSU), one transaction outstanding at a time.
//
// Ports
//   clk, rst                     clock, synchronous active-high reset
//   m_req_valid/ready            per-master request handshake
//   m_req_addr/wen/wdata/wmask   packed per-master request fields (master i at [i*W +: W])
//   m_rsp_valid/ready            per-master response handshake
//   m_rsp_rdata                  SRAM read data, broadcast to every master
//   s_req_*                      forwarded request to the SRAM
//   s_rsp_valid/ready/rdata      SRAM response channel
//   grant                        registered one-hot owner, 0 when idle
//
// Build option: define ARB_RR_EN for round-robin arbitration; otherwise the
// highest-index valid master wins and no priority pointer is built.
module mem_arbiter #(
  parameter int unsigned NREQ = 2,
  parameter int unsigned AW   = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NREQ-1:0]    m_req_valid,
  output logic [NREQ-1:0]    m_req_ready,
  input  logic [NREQ*AW-1:0] m_req_addr,
  input  logic [NREQ-1:0]    m_req_wen,
  input  logic [NREQ*32-1:0] m_req_wdata,
  input  logic [NREQ*4-1:0]  m_req_wmask,
  output logic [NREQ-1:0]    m_rsp_valid,
  input  logic [NREQ-1:0]    m_rsp_ready,
  output logic [31:0]        m_rsp_rdata,
  output logic               s_req_valid,
  input  logic               s_req_ready,
  output logic [AW-1:0]      s_req_addr,
  output logic               s_req_wen,
  output logic [31:0]        s_req_wdata,
  output logic [3:0]         s_req_wmask,
  input  logic               s_rsp_valid,
  output logic               s_rsp_ready,
  input  logic [31:0]        s_rsp_rdata,
  output logic [NREQ-1:0]    grant
);

  localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_RSP  = 2'd2;

  logic [1:0]      state, state_nxt;
  logic [NREQ-1:0] grant_nxt;
  logic [IW-1:0]   owner;
  logic [IW-1:0]   win_idx;

  logic [AW-1:0]   addr_arr  [NREQ];
  logic [31:0]     wdata_arr [NREQ];
  logic [3:0]      wmask_arr [NREQ];

`ifdef ARB_RR_EN
  logic [IW-1:0]   ptr, ptr_nxt;
`endif

  // Unpack the flat master buses so the owner can select by index
  for (genvar i = 0; i < int'(NREQ); i++) begin : g_unpack
    assign addr_arr[i]  = m_req_addr[i*AW +: AW];
    assign wdata_arr[i] = m_req_wdata[i*32 +: 32];
    assign wmask_arr[i] = m_req_wmask[i*4 +: 4];
  end

  // Owner index decoded from the registered one-hot grant
  always_comb begin
    owner = '0;
    for (int i = 0; i < int'(NREQ); i++) begin
      if (grant[i]) owner = IW'(i);
    end
  end

  // Arbitration winner among currently valid masters
  always_comb begin
    win_idx = '0;
`ifdef ARB_RR_EN
    // Walk downward in offset so the closest valid master at/after ptr wins
    for (int k = int'(NREQ) - 1; k >= 0; k--) begin
      if (m_req_valid[IW'((int'(ptr) + k) % int'(NREQ))])
        win_idx = IW'((int'(ptr) + k) % int'(NREQ));
    end
`else
    for (int i = 0; i < int'(NREQ); i++) begin
      if (m_req_valid[i]) win_idx = IW'(i);
    end
`endif
  end

  // State, grant and pointer registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      grant <= '0;
`ifdef ARB_RR_EN
      ptr   <= '0;
`endif
    end else begin
      state <= state_nxt;
      grant <= grant_nxt;
`ifdef ARB_RR_EN
      ptr   <= ptr_nxt;
`endif
    end
  end

  // Next-state and forwarding logic, all driven from the registered grant
  always_comb begin
    state_nxt   = state;
    grant_nxt   = grant;
`ifdef ARB_RR_EN
    ptr_nxt     = ptr;
`endif
    m_req_ready = '0;
    m_rsp_valid = '0;
    s_req_valid = 1'b0;
    s_rsp_ready = 1'b0;
    s_req_addr  = addr_arr[owner];
    s_req_wen   = m_req_wen[owner];
    s_req_wdata = wdata_arr[owner];
    s_req_wmask = wmask_arr[owner];

    case (state)
      S_IDLE: begin
        // No ready here: arbitration takes one full cycle
        if (|m_req_valid) begin
          grant_nxt = NREQ'(1) << win_idx;
          state_nxt = S_REQ;
        end
      end
      S_REQ: begin
        s_req_valid        = m_req_valid[owner];
        m_req_ready[owner] = s_req_ready;
        if (m_req_valid[owner] && s_req_ready) state_nxt = S_RSP;
      end
      S_RSP: begin
        m_rsp_valid[owner] = s_rsp_valid;
        s_rsp_ready        = m_rsp_ready[owner];
        if (s_rsp_valid && m_rsp_ready[owner]) begin
          state_nxt = S_IDLE;
          grant_nxt = '0;
`ifdef ARB_RR_EN
          ptr_nxt   = IW'((int'(owner) + 1) % int'(NREQ));
`endif
        end
      end
      default: begin
        state_nxt = S_IDLE;
        grant_nxt = '0;
      end
    endcase
  end

  assign m_rsp_rdata = s_rsp_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: table-driven transactions plus hand-written corner cases;
// response data/owner checked through a scoreboard queue.
module tb_mem_arbiter;

  localparam int unsigned NREQ = 2;
  localparam int unsigned AW   = 32;

  logic              clk = 1'b0;
  logic              rst;
  logic [NREQ-1:0]   m_req_valid, m_req_ready, m_req_wen;
  logic [NREQ*AW-1:0] m_req_addr;
  logic [NREQ*32-1:0] m_req_wdata;
  logic [NREQ*4-1:0] m_req_wmask;
  logic [NREQ-1:0]   m_rsp_valid, m_rsp_ready;
  logic [31:0]       m_rsp_rdata;
  logic              s_req_valid, s_req_ready, s_req_wen;
  logic [AW-1:0]     s_req_addr;
  logic [31:0]       s_req_wdata;
  logic [3:0]        s_req_wmask;
  logic              s_rsp_valid, s_rsp_ready;
  logic [31:0]       s_rsp_rdata;
  logic [NREQ-1:0]   grant;

  mem_arbiter #(.NREQ(NREQ), .AW(AW)) dut (
    .clk(clk), .rst(rst),
    .m_req_valid(m_req_valid), .m_req_ready(m_req_ready), .m_req_addr(m_req_addr),
    .m_req_wen(m_req_wen), .m_req_wdata(m_req_wdata), .m_req_wmask(m_req_wmask),
    .m_rsp_valid(m_rsp_valid), .m_rsp_ready(m_rsp_ready), .m_rsp_rdata(m_rsp_rdata),
    .s_req_valid(s_req_valid), .s_req_ready(s_req_ready), .s_req_addr(s_req_addr),
    .s_req_wen(s_req_wen), .s_req_wdata(s_req_wdata), .s_req_wmask(s_req_wmask),
    .s_rsp_valid(s_rsp_valid), .s_rsp_ready(s_rsp_ready), .s_rsp_rdata(s_rsp_rdata),
    .grant(grant)
  );

  always #5 clk = ~clk;

  // Per-master request fields held by the bench
  logic [AW-1:0] f_addr  [NREQ];
  logic          f_wen   [NREQ];
  logic [31:0]   f_wdata [NREQ];
  logic [3:0]    f_wmask [NREQ];

  always_comb begin
    for (int i = 0; i < int'(NREQ); i++) begin
      m_req_addr[i*AW +: AW] = f_addr[i];
      m_req_wen[i]           = f_wen[i];
      m_req_wdata[i*32 +: 32] = f_wdata[i];
      m_req_wmask[i*4 +: 4]  = f_wmask[i];
    end
  end

  typedef struct {
    logic [1:0]  new_valid;
    logic [31:0] addr0;  logic wen0; logic [31:0] wdata0; logic [3:0] wmask0;
    logic [31:0] addr1;  logic wen1; logic [31:0] wdata1; logic [3:0] wmask1;
    logic [1:0]  exp_grant;
    logic [31:0] rdata;
    int          req_stall;
    int          rsp_stall;
  } vec_t;

  typedef struct {
    logic [1:0]  owner;
    logic [31:0] rdata;
  } sb_t;

  sb_t  sb[$];
  int   checks = 0;
  int   errors = 0;
  logic ptr_m  = 1'b0;

`ifdef ARB_RR_EN
  localparam logic [1:0] G_BOTH_FIRST  = 2'b01;
  localparam logic [1:0] G_BOTH_SECOND = 2'b10;
`else
  localparam logic [1:0] G_BOTH_FIRST  = 2'b10;
  localparam logic [1:0] G_BOTH_SECOND = 2'b01;
`endif

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference winner among valid masters given the bench's pointer copy
  function automatic logic pick(input logic [1:0] v, input logic p);
`ifdef ARB_RR_EN
    if (v == 2'b11) return p;
    return v[1];
`else
    return v[1];
`endif
  endfunction

  // Serve one transaction for master ix starting from IDLE with its valid set
  task automatic serve(input logic ix, input logic [31:0] rdata,
                       input int req_stall, input int rsp_stall);
    logic [1:0] eg;
    eg = 2'b01 << ix;
    tick();
    chk("grant_after_arb", grant, eg);
    chk("s_req_valid", s_req_valid, 1'b1);
    chk("s_req_addr", s_req_addr, f_addr[ix]);
    chk("s_req_wen", s_req_wen, f_wen[ix]);
    chk("s_req_wdata", s_req_wdata, f_wdata[ix]);
    chk("s_req_wmask", s_req_wmask, f_wmask[ix]);
    chk("m_req_ready_wait", m_req_ready, 2'b00);
    for (int s = 0; s < req_stall; s++) begin
      tick();
      chk("req_stall_grant", grant, eg);
      chk("req_stall_addr", s_req_addr, f_addr[ix]);
      chk("req_stall_ready", m_req_ready, 2'b00);
    end
    s_req_ready = 1'b1;
    #1;
    chk("m_req_ready_owner", m_req_ready, eg);
    tick();
    s_req_ready = 1'b0;
    m_req_valid = m_req_valid & ~eg;
    #1;
    chk("rsp_wait_grant", grant, eg);
    chk("rsp_wait_valid", m_rsp_valid, 2'b00);
    chk("rsp_wait_sreq", s_req_valid, 1'b0);
    tick();
    s_rsp_valid = 1'b1;
    s_rsp_rdata = rdata;
    sb.push_back('{eg, rdata});
    if (rsp_stall > 0) m_rsp_ready = ~eg;
    #1;
    chk("m_rsp_valid", m_rsp_valid, eg);
    chk("m_rsp_rdata", m_rsp_rdata, rdata);
    for (int s = 0; s < rsp_stall; s++) begin
      tick();
      chk("rsp_stall_grant", grant, eg);
      chk("rsp_stall_srdy", s_rsp_ready, 1'b0);
    end
    m_rsp_ready = '1;
    #1;
    chk("s_rsp_ready", s_rsp_ready, 1'b1);
    tick();
    s_rsp_valid = 1'b0;
    #1;
    chk("grant_cleared", grant, 2'b00);
    chk("s_rsp_ready_idle", s_rsp_ready, 1'b0);
    ptr_m = ~ix;
  endtask

  // Scoreboard: compare owner and data on every response handshake
  always @(negedge clk) begin
    if (!rst && (|(m_rsp_valid & m_rsp_ready))) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_unexpected: got response owner %b expected none", m_rsp_valid);
      end else begin
        sb_t e;
        e = sb.pop_front();
        chk("sb_owner", m_rsp_valid, e.owner);
        chk("sb_rdata", m_rsp_rdata, e.rdata);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    vec_t vecs[5];
    logic w;
    vecs[0] = '{2'b01, 32'h8000_0000, 1'b0, 32'h0, 4'h0, 32'h0, 1'b0, 32'h0, 4'h0,
                2'b01, 32'h0010_0093, 0, 0};
    vecs[1] = '{2'b10, 32'h8000_0000, 1'b0, 32'h0, 4'h0, 32'h8000_1000, 1'b1, 32'hDEAD_BEEF, 4'hF,
                2'b10, 32'h0000_0000, 0, 0};
    vecs[2] = '{2'b11, 32'h8000_0004, 1'b0, 32'h0, 4'h0, 32'h8000_2000, 1'b0, 32'h0, 4'h3,
                G_BOTH_FIRST, 32'h1111_2222, 0, 0};
    vecs[3] = '{2'b00, 32'h0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b0, 32'h0, 4'h0,
                G_BOTH_SECOND, 32'h3333_4444, 0, 0};
    vecs[4] = '{2'b01, 32'h8000_0010, 1'b0, 32'h0, 4'h0, 32'h0, 1'b0, 32'h0, 4'h0,
                2'b01, 32'h5555_6666, 3, 2};

    rst = 1'b1;
    m_req_valid = '0;
    m_rsp_ready = '1;
    s_req_ready = 1'b0;
    s_rsp_valid = 1'b0;
    s_rsp_rdata = '0;
    for (int i = 0; i < int'(NREQ); i++) begin
      f_addr[i] = '0; f_wen[i] = 1'b0; f_wdata[i] = '0; f_wmask[i] = '0;
    end
    tick();
    tick();
    rst = 1'b0;
    #1;
    chk("rst_grant", grant, 2'b00);
    chk("rst_m_req_ready", m_req_ready, 2'b00);
    chk("rst_m_rsp_valid", m_rsp_valid, 2'b00);
    chk("rst_s_req_valid", s_req_valid, 1'b0);
    chk("rst_s_rsp_ready", s_rsp_ready, 1'b0);

    // Table-driven transactions
    for (int v = 0; v < 5; v++) begin
      if (vecs[v].new_valid[0]) begin
        f_addr[0] = vecs[v].addr0; f_wen[0] = vecs[v].wen0;
        f_wdata[0] = vecs[v].wdata0; f_wmask[0] = vecs[v].wmask0;
      end
      if (vecs[v].new_valid[1]) begin
        f_addr[1] = vecs[v].addr1; f_wen[1] = vecs[v].wen1;
        f_wdata[1] = vecs[v].wdata1; f_wmask[1] = vecs[v].wmask1;
      end
      m_req_valid = m_req_valid | vecs[v].new_valid;
      serve(vecs[v].exp_grant[1], vecs[v].rdata, vecs[v].req_stall, vecs[v].rsp_stall);
    end

    // Stray slave handshakes while idle are ignored
    s_req_ready = 1'b1;
    s_rsp_valid = 1'b1;
    #1;
    chk("idle_s_rsp_ready", s_rsp_ready, 1'b0);
    chk("idle_m_rsp_valid", m_rsp_valid, 2'b00);
    chk("idle_m_req_ready", m_req_ready, 2'b00);
    tick();
    chk("idle_grant", grant, 2'b00);
    s_req_ready = 1'b0;
    s_rsp_valid = 1'b0;

    // Reset while IFU owns the SRAM in the response phase
    f_addr[0] = 32'h8000_0020; f_wen[0] = 1'b0;
    m_req_valid = 2'b01;
    tick();
    chk("rstmid_grant", grant, 2'b01);
    s_req_ready = 1'b1;
    tick();
    s_req_ready = 1'b0;
    m_req_valid = 2'b00;
    m_rsp_ready = 2'b00;
    s_rsp_valid = 1'b1;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    ptr_m = 1'b0;
    #1;
    chk("rstmid_grant_clr", grant, 2'b00);
    chk("rstmid_m_rsp_valid", m_rsp_valid, 2'b00);
    chk("rstmid_s_rsp_ready", s_rsp_ready, 1'b0);
    chk("rstmid_s_req_valid", s_req_valid, 1'b0);
    chk("rstmid_m_req_ready", m_req_ready, 2'b00);
    s_rsp_valid = 1'b0;
    m_rsp_ready = '1;
    m_req_valid = 2'b01;
    serve(1'b0, 32'h0000_0013, 0, 0);

    // Both masters request continuously
    f_addr[0] = 32'h8000_0100; f_wen[0] = 1'b0;
    f_addr[1] = 32'h8000_3000; f_wen[1] = 1'b0;
    m_req_valid = 2'b11;
    for (int t = 0; t < 10; t++) begin
      w = pick(m_req_valid, ptr_m);
      serve(w, 32'hA000_0000 + 32'(t), 0, 0);
      m_req_valid = 2'b11;
    end
    for (int t = 0; t < 2; t++) begin
      w = pick(m_req_valid, ptr_m);
      serve(w, 32'hB000_0000 + 32'(t), 0, 0);
    end

    tick();
    chk("sb_drained", 64'(sb.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Sequences a single-port instruction/data SRAM and shares it among NREQ requesters: index 0 is the IFU fetch path, index 1 is the LSU.
- Uses one outstanding transaction at a time, with a valid/ready request channel and a valid/ready response channel on each side.
- Sits between the IFU/LSU and the SRAM slave, replacing their private SRAM instances.
- Master and slave sides use the same request/response protocol.

Parameters:
NREQ, 2, number of requesters; higher index = higher fixed priority
AW, 32, address width

Ports:
clk  input  1  clock
rst  input  1  reset, synchronous, active-high
m_req_valid  input  NREQ  per-master request valid
m_req_ready  output  NREQ  per-master request accepted
m_req_addr  input  NREQ*AW  packed addresses, master i at [i*AW +: AW]
m_req_wen  input  NREQ  1 = write, 0 = read
m_req_wdata  input  NREQ*32  packed write data
m_req_wmask  input  NREQ*4  packed byte strobes
m_rsp_valid  output  NREQ  per-master response valid
m_rsp_ready  input  NREQ  per-master response ready
m_rsp_rdata  output  32  read data, broadcast to all masters
s_req_valid  output  1  request valid to SRAM
s_req_ready  input  1  SRAM accepts request
s_req_addr  output  AW  forwarded address
s_req_wen  output  1  forwarded write enable
s_req_wdata  output  32  forwarded write data
s_req_wmask  output  4  forwarded strobes
s_rsp_valid  input  1  SRAM response valid (read data or write ack)
s_rsp_ready  output  1  response ready to SRAM
s_rsp_rdata  input  32  SRAM read data
grant  output  NREQ  one-hot registered owner; 0 when idle

Behaviour:
- Reset: state IDLE, grant = 0, priority pointer = 0. All outputs low: m_req_ready, m_rsp_valid, s_req_valid, s_rsp_ready.
- States: IDLE, REQ, RSP. The state and grant are registered; all forwarding is combinational from the registered grant.
- IDLE:
  - If any m_req_valid is set, grant the highest-index valid master. Grant is registered on the edge and the state goes to REQ.
  - No ready is asserted in IDLE, so arbitration costs exactly 1 cycle.
- REQ (owner g):
  - s_req_* = master g's fields; s_req_valid = m_req_valid[g]; m_req_ready[g] = s_req_ready.
  - On s_req_valid && s_req_ready, go to RSP.
  - Masters must hold valid and fields stable until ready. If valid drops, the arbiter stays in REQ with s_req_valid low.
- RSP:
  - m_rsp_valid[g] = s_rsp_valid; s_rsp_ready = m_rsp_ready[g].
  - On the response handshake, go to IDLE and clear grant.
  - A new request is considered in the following IDLE cycle; there is no back-to-back bypass.
- Non-owners always see m_req_ready = 0 and m_rsp_valid = 0. m_rsp_rdata = s_rsp_rdata at all times.
- Requests arriving during REQ/RSP wait; valid stays asserted and is not dropped.
- Simultaneous requests in IDLE: only one is granted; the loser remains pending.
- Slave ready or valid asserted outside the matching state is ignored; s_*_ready stays 0.
- Reset mid-transaction: returns to IDLE on the next edge and the transaction is abandoned. The SRAM shares rst, so no orphan response arrives.
- Write responses carry no data; masters ignore m_rsp_rdata on writes.

Optional Feature:
ARB_RR_EN
- Defined: round-robin arbitration. The pointer is updated to (granted index + 1) mod NREQ on each response handshake. In IDLE, the first valid master at or after the pointer wins.
- Undefined: fixed priority, highest index wins; the pointer register is not built.

Test Plan:
- IFU-only read: m_req_valid=01, addr0=0x80000000; SRAM returns 0x00100093 after 2 cycles.
  - Expect grant=01 one cycle after valid, s_req_addr=0x80000000, m_rsp_valid=01 with rdata 0x00100093, then grant=00.
- Simultaneous requests: m_req_valid=11 in IDLE, fixed priority.
  - Expect the LSU (grant=10) served first and IFU granted in the IDLE after the LSU response.
  - With ARB_RR_EN and pointer=0, expect IFU first.
- LSU write: wen=1, addr=0x80001000, wdata=0xDEADBEEF, wmask=0xF.
  - Expect s_req_* to match exactly, the response handshake with s_rsp_ready=1 only for owner 1, and IFU m_req_ready=0 throughout.
- Backpressure: s_req_ready low for 3 cycles, then m_rsp_ready[0] low for 2 cycles after s_rsp_valid.
  - Expect state held, fields stable, and no transition until each handshake.
- Reset in RSP: assert rst while grant=01.
  - Expect grant=0, all valid/ready outputs 0 on the next edge, and normal fetch afterwards.
- Starvation check, ARB_RR_EN: both masters request continuously for 10 transactions.
  - Expect strictly alternating grants 10,01,10,…
